// File: rtl/point_double_jacobian.sv
// point_double_jacobian: doubles one SM2 point in Jacobian coordinates using the
// a = -3 formulas, with one shared modular multiplier and a one-op-per-cycle add/sub unit.

// Bit-serial interleaved modular multiplier: c = a*b mod P, MSB-first, 256 steps.
module mod_mul256_p #(
    parameter logic [255:0] P = 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic [255:0] a,
    input  logic [255:0] b,
    output logic [255:0] c,
    output logic         done
);
    logic [255:0] ra, rb, acc, nxt;
    logic [7:0]   cnt;
    logic         run;
    logic [256:0] dbl, dbl_sub, dbl_r, sum, sum_sub;

    // one double-and-add step, each stage folded back below P
    always_comb begin
        dbl     = {acc, 1'b0};
        dbl_sub = dbl - {1'b0, P};
        dbl_r   = (dbl >= {1'b0, P}) ? dbl_sub : dbl;
        sum     = dbl_r + (rb[255] ? {1'b0, ra} : '0);
        sum_sub = sum - {1'b0, P};
        nxt     = (sum >= {1'b0, P}) ? sum_sub[255:0] : sum[255:0];
    end

    // operand capture, iteration counter and result/done registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ra   <= '0;
            rb   <= '0;
            acc  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            c    <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !run) begin
                ra  <= a;
                rb  <= b;
                acc <= '0;
                cnt <= '0;
                run <= 1'b1;
            end else if (run) begin
                acc <= nxt;
                rb  <= {rb[254:0], 1'b0};
                cnt <= cnt + 8'd1;
                if (cnt == 8'd255) begin
                    run  <= 1'b0;
                    c    <= nxt;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

module point_double_jacobian #(
    parameter logic [255:0] P = 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [255:0] xin,
    input  logic [255:0] yin,
    input  logic [255:0] zin,
    input  logic         start,
    output logic [255:0] xout,
    output logic [255:0] yout,
    output logic [255:0] zout,
    output logic         busy,
    output logic         done
);
    typedef enum logic [2:0] {IDLE, MUL_P, MUL_W, ALU, FIN} state_t;

    // pc walks a fixed 24-step program; steps listed in step_is_mul are multiplies
    localparam logic [4:0] LAST_STEP = 5'd23;

    state_t       state, state_n;
    logic [4:0]   pc, pc_inc;
    logic [255:0] x, y, z, delta, gamma, beta, b4, b8, u, v, w, alpha, e, x3, z3, tmp, prod;
    logic [255:0] mul_a, mul_b, mul_c, m_a, m_b, al_a, al_b, res;
    logic         mul_start, mul_done, al_sub;
    logic [256:0] add_s, add_r, sub_d, sub_r;

    function automatic logic step_is_mul(input logic [4:0] s);
        case (s)
            5'd0, 5'd1, 5'd2, 5'd8, 5'd11, 5'd14, 5'd17, 5'd22: step_is_mul = 1'b1;
            default: step_is_mul = 1'b0;
        endcase
    endfunction

    assign pc_inc = pc + 5'd1;

    mod_mul256_p #(.P(P)) u_mul (
        .clk(clk), .rstn(rstn), .start(mul_start),
        .a(mul_a), .b(mul_b), .c(mul_c), .done(mul_done)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    // next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = MUL_P;
            MUL_P:   state_n = MUL_W;
            MUL_W:   if (mul_done) state_n = step_is_mul(pc_inc) ? MUL_P : ALU;
            ALU:     state_n = (pc == LAST_STEP) ? FIN : (step_is_mul(pc_inc) ? MUL_P : ALU);
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // status outputs
    always_comb begin
        busy = (state != IDLE);
        done = (state == FIN);
    end

    // multiplier operand selection per program step
    always_comb begin
        m_a = '0;
        m_b = '0;
        case (pc)
            5'd0:    begin m_a = z;     m_b = z;     end
            5'd1:    begin m_a = y;     m_b = y;     end
            5'd2:    begin m_a = x;     m_b = gamma; end
            5'd8:    begin m_a = u;     m_b = v;     end
            5'd11:   begin m_a = alpha; m_b = alpha; end
            5'd14:   begin m_a = w;     m_b = w;     end
            5'd17:   begin m_a = gamma; m_b = gamma; end
            5'd22:   begin m_a = alpha; m_b = e;     end
            default: ;
        endcase
    end

    // modular add/sub unit with operand selection per program step
    always_comb begin
        al_a   = '0;
        al_b   = '0;
        al_sub = 1'b0;
        case (pc)
            5'd3:    begin al_a = beta;  al_b = beta;  end
            5'd4:    begin al_a = tmp;   al_b = tmp;   end
            5'd5:    begin al_a = b4;    al_b = b4;    end
            5'd6:    begin al_a = x;     al_b = delta; al_sub = 1'b1; end
            5'd7:    begin al_a = x;     al_b = delta; end
            5'd9:    begin al_a = prod;  al_b = prod;  end
            5'd10:   begin al_a = tmp;   al_b = prod;  end
            5'd12:   begin al_a = prod;  al_b = b8;    al_sub = 1'b1; end
            5'd13:   begin al_a = y;     al_b = z;     end
            5'd15:   begin al_a = prod;  al_b = gamma; al_sub = 1'b1; end
            5'd16:   begin al_a = tmp;   al_b = delta; al_sub = 1'b1; end
            5'd18:   begin al_a = prod;  al_b = prod;  end
            5'd19:   begin al_a = tmp;   al_b = tmp;   end
            5'd20:   begin al_a = tmp;   al_b = tmp;   end
            5'd21:   begin al_a = b4;    al_b = x3;    al_sub = 1'b1; end
            5'd23:   begin al_a = prod;  al_b = tmp;   al_sub = 1'b1; end
            default: ;
        endcase
        add_s = {1'b0, al_a} + {1'b0, al_b};
        add_r = add_s - {1'b0, P};
        sub_d = {1'b0, al_a} - {1'b0, al_b};
        sub_r = sub_d + {1'b0, P};
        if (al_sub) res = sub_d[256] ? sub_r[255:0] : sub_d[255:0];
        else        res = (add_s >= {1'b0, P}) ? add_r[255:0] : add_s[255:0];
    end

    // datapath: input latch, multiplier handshake, temporaries and result registers.
    // tmp is reused for b2, a2, z1 and the g2/g4/g8 chain; prod holds t, sq, s6, g and m,
    // each consumed before the next multiply overwrites it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc <= '0; mul_start <= 1'b0; mul_a <= '0; mul_b <= '0;
            x <= '0; y <= '0; z <= '0; delta <= '0; gamma <= '0; beta <= '0;
            b4 <= '0; b8 <= '0; u <= '0; v <= '0; w <= '0; alpha <= '0; e <= '0;
            x3 <= '0; z3 <= '0; tmp <= '0; prod <= '0;
            xout <= '0; yout <= '0; zout <= '0;
        end else begin
            mul_start <= 1'b0;
            case (state)
                IDLE: begin
                    x  <= xin;
                    y  <= yin;
                    z  <= zin;
                    pc <= '0;
                end
                MUL_P: begin
                    mul_a     <= m_a;
                    mul_b     <= m_b;
                    mul_start <= 1'b1;
                end
                MUL_W: if (mul_done) begin
                    case (pc)
                        5'd0:    delta <= mul_c;
                        5'd1:    gamma <= mul_c;
                        5'd2:    beta  <= mul_c;
                        default: prod  <= mul_c;
                    endcase
                    pc <= pc_inc;
                end
                ALU: begin
                    case (pc)
                        5'd4:    b4    <= res;
                        5'd5:    b8    <= res;
                        5'd6:    u     <= res;
                        5'd7:    v     <= res;
                        5'd10:   alpha <= res;
                        5'd12:   x3    <= res;
                        5'd13:   w     <= res;
                        5'd16:   z3    <= res;
                        5'd21:   e     <= res;
                        5'd23:   begin yout <= res; xout <= x3; zout <= z3; end
                        default: tmp   <= res;
                    endcase
                    pc <= pc_inc;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_point_double_jacobian.sv
// Bench for point_double_jacobian: field-arithmetic reference model, scoreboard on done,
// directed SM2 points, random points, start-while-busy and reset-abort scenarios.
module tb_point_double_jacobian;
    localparam logic [255:0] P  = 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF;
    localparam logic [255:0] CB = 256'h28E9FA9E9D9F5E344D5A9E4BCF6509A7F39789F515AB8F92DDBCBD414D940E93;
    localparam logic [255:0] GX = 256'h32C4AE2C1F1981195F9904466A39C9948FE30BBFF2660BE1715A4589334C74C7;
    localparam logic [255:0] GY = 256'hBC3736A2F4F6779C59BDCEE36B692153D0A9877CC62A474002DF32E52139F0A0;
    localparam int TIMEOUT = 20000;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start = 1'b0;
    logic [255:0] xin = '0, yin = '0, zin = '0;
    logic [255:0] xout, yout, zout;
    logic         busy, done;

    int n_checks = 0;
    int n_fail = 0;
    logic [767:0] exp_q[$];
    logic [767:0] last_res = '0;

    always #5 clk = ~clk;

    point_double_jacobian #(.P(P)) dut (
        .clk(clk), .rstn(rstn), .xin(xin), .yin(yin), .zin(zin), .start(start),
        .xout(xout), .yout(yout), .zout(zout), .busy(busy), .done(done)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [255:0] mm(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] p;
        p = {256'b0, a} * {256'b0, b};
        p = p % {256'b0, P};
        return p[255:0];
    endfunction

    function automatic logic [255:0] ad(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] s;
        s = ({1'b0, a} + {1'b0, b}) % {1'b0, P};
        return s[255:0];
    endfunction

    function automatic logic [255:0] sb(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] s;
        s = ({1'b0, a} + {1'b0, P} - {1'b0, b}) % {1'b0, P};
        return s[255:0];
    endfunction

    // textbook a=-3 Jacobian doubling in closed form
    task automatic model(input logic [255:0] x, y, z, output logic [255:0] x3, y3, z3);
        logic [255:0] delta, gamma, beta, alpha;
        delta = mm(z, z);
        gamma = mm(y, y);
        beta  = mm(x, gamma);
        alpha = mm(256'd3, mm(sb(x, delta), ad(x, delta)));
        x3 = sb(mm(alpha, alpha), mm(256'd8, beta));
        z3 = sb(mm(ad(y, z), ad(y, z)), ad(gamma, delta));
        y3 = sb(mm(alpha, sb(mm(256'd4, beta), x3)), mm(256'd8, mm(gamma, gamma)));
    endtask

    // Y^2 == X^3 - 3 X Z^4 + b Z^6
    function automatic logic on_curve(input logic [255:0] x, y, z);
        logic [255:0] z2, z4, z6, lhs, rhs;
        z2  = mm(z, z);
        z4  = mm(z2, z2);
        z6  = mm(z4, z2);
        lhs = mm(y, y);
        rhs = ad(sb(mm(mm(x, x), x), mm(256'd3, mm(x, z4))), mm(CB, z6));
        return lhs == rhs;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r % P;
    endfunction

    // scoreboard: compare on done, and require outputs to hold while idle
    always @(negedge clk) begin
        if (rstn) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 required no done");
                end else begin
                    last_res = exp_q.pop_front();
                    check("xout", xout, last_res[767:512]);
                    check("yout", yout, last_res[511:256]);
                    check("zout", zout, last_res[255:0]);
                end
            end else if (!busy) begin
                check("xout_hold", xout, last_res[767:512]);
                check("yout_hold", yout, last_res[511:256]);
                check("zout_hold", zout, last_res[255:0]);
            end
        end
    end

    task automatic run_op(input logic [255:0] x, y, z, input bit disturb, input int abort_at,
                          output int lat);
        logic [255:0] ex, ey, ez;
        bit busy_ok;
        bit got;
        busy_ok = 1'b1;
        got = 1'b0;
        model(x, y, z, ex, ey, ez);
        @(negedge clk);
        xin = x; yin = y; zin = z; start = 1'b1;
        exp_q.push_back({ex, ey, ez});
        @(negedge clk);
        start = 1'b0;
        xin = rand256(); yin = rand256(); zin = rand256();
        lat = 1;
        while (lat < TIMEOUT) begin
            if (done) begin got = 1'b1; break; end
            if (!busy) busy_ok = 1'b0;
            if (abort_at != 0 && lat == abort_at) begin
                rstn = 1'b0;
                exp_q.delete();
                last_res = '0;
                @(negedge clk);
                rstn = 1'b1;
                check("abort_xout", xout, '0);
                check("abort_yout", yout, '0);
                check("abort_zout", zout, '0);
                check("abort_busy", {255'b0, busy}, '0);
                check("abort_done", {255'b0, done}, '0);
                got = 1'b0;
                for (int i = 0; i < 2500; i++) begin
                    if (done) got = 1'b1;
                    @(negedge clk);
                end
                check("abort_no_done", {255'b0, got}, '0);
                return;
            end
            if (disturb && lat == 5) begin start = 1'b1; xin = rand256(); zin = rand256(); end
            if (disturb && lat == 6) start = 1'b0;
            @(negedge clk);
            lat++;
        end
        check("done_seen", {255'b0, got}, 256'd1);
        if (!got) exp_q.delete();
        check("busy_until_done", {255'b0, busy_ok}, 256'd1);
        check("latency_min", {255'b0, (lat >= 33)}, 256'd1);
        @(negedge clk);
        check("done_single", {255'b0, done}, '0);
        check("idle_after", {255'b0, busy}, '0);
    endtask

    initial begin
        logic [255:0] ex, ey, ez;
        int lat, lat_g;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_xout", xout, '0);
        check("rst_yout", yout, '0);
        check("rst_zout", zout, '0);
        check("rst_busy", {255'b0, busy}, '0);
        check("rst_done", {255'b0, done}, '0);
        rstn = 1'b1;

        // hand-derived values pin the model
        model(256'd1, 256'd1, 256'd1, ex, ey, ez);
        check("model111_x", ex, P - 256'd8);
        check("model111_y", ey, P - 256'd8);
        check("model111_z", ez, 256'd2);
        model(256'd2, 256'd1, 256'd1, ex, ey, ez);
        check("model211_x", ex, 256'd65);
        check("model211_y", ey, P - 256'd521);
        check("g_on_curve", {255'b0, on_curve(GX, GY, 256'd1)}, 256'd1);
        model(GX, GY, 256'd1, ex, ey, ez);
        check("model_2g_on_curve", {255'b0, on_curve(ex, ey, ez)}, 256'd1);

        run_op(256'd1, 256'd1, 256'd1, 1'b0, 0, lat);
        check("dut111_x", xout, P - 256'd8);
        check("dut111_y", yout, P - 256'd8);
        check("dut111_z", zout, 256'd2);

        run_op(256'd2, 256'd1, 256'd1, 1'b0, 0, lat);
        check("dut211_x", xout, 256'd65);
        check("dut211_y", yout, P - 256'd521);
        check("dut211_z", zout, 256'd2);

        run_op(GX, GY, 256'd1, 1'b1, 0, lat_g);
        check("dut_2g_on_curve", {255'b0, on_curve(xout, yout, zout)}, 256'd1);

        run_op(rand256(), rand256(), 256'd0, 1'b0, 0, lat);
        check("inf_z", zout, '0);

        for (int i = 0; i < 4; i++) run_op(rand256(), rand256(), rand256(), i[0], 0, lat);

        run_op(rand256(), rand256(), rand256(), 1'b0, lat_g * 55 / 100, lat);
        run_op(GX, GY, 256'd1, 1'b0, 0, lat);
        check("after_abort_on_curve", {255'b0, on_curve(xout, yout, zout)}, 256'd1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
